// File: rtl/led_wave_scanner_if.sv
// Control/status bundle for led_wave_scanner.
// master: user logic driving en/mode/rate/duty and reading q/pos/wrap; slave: the scanner.
interface led_wave_scanner_if #(
    parameter int N_LED   = 8,
    parameter int PRESC_W = 16
);
    localparam int POS_W = $clog2(N_LED);

    logic               en;
    logic [1:0]         mode;
    logic [PRESC_W-1:0] rate;
    logic [3:0]         duty;
    logic [N_LED-1:0]   q;
    logic [POS_W-1:0]   pos;
    logic               wrap;

    modport master (
        output en, mode, rate, duty,
        input  q, pos, wrap
    );

    modport slave (
        input  en, mode, rate, duty,
        output q, pos, wrap
    );
endinterface

// File: rtl/led_wave_scanner.sv
// LED pattern generator: prescaled position counter (bounce/rotate/bar/hold) plus 16-level PWM.
// Ports: clk, rst (sync, active-high), bus (slave: en, mode, rate, duty in; q, pos, wrap out).
module led_wave_scanner #(
    parameter int N_LED   = 8,
    parameter int PRESC_W = 16
) (
    input logic              clk,
    input logic              rst,
    led_wave_scanner_if.slave bus
);
    localparam int POS_W = $clog2(N_LED);
    localparam logic [POS_W-1:0] LAST   = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] PENULT = POS_W'(N_LED - 2);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRESC_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    dir_e               dir_q, dir_d;
    logic [3:0]         pwm_q, pwm_d;
    logic [N_LED-1:0]   q_q, q_d;
    logic               wrap_q, wrap_d;
    logic [N_LED-1:0]   pat;
    logic               tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            pwm_q  <= '0;
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            pwm_q  <= pwm_d;
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    // Prescaler and position next state.
    // The >= compare lets a lowered rate fire on the next enabled cycle.
    always_comb begin
        tick  = bus.en && (cnt_q >= bus.rate);
        cnt_d = cnt_q;
        pos_d = pos_q;
        dir_d = dir_q;
        if (bus.en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
        if (tick) begin
            unique case (bus.mode)
                2'd0: begin
                    if (dir_q == DIR_UP) begin
                        if (pos_q == LAST) begin
                            pos_d = PENULT;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_W'(1);
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                end
                2'd1, 2'd2: begin
                    dir_d = DIR_UP;
                    pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
        wrap_d = tick && (pos_d == '0) && (pos_q != '0);
    end

    // One-hot marker, or thermometer in bar mode.
    always_comb begin
        pat = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (bus.mode == 2'd2) begin
                pat[i] = (POS_W'(i) <= pos_q);
            end else begin
                pat[i] = (POS_W'(i) == pos_q);
            end
        end
    end

    // PWM free-runs regardless of en so a frozen pattern keeps its brightness.
    always_comb begin
        pwm_d = pwm_q + 4'd1;
        q_d   = (pwm_q < bus.duty) ? pat : '0;
    end

    assign bus.q    = q_q;
    assign bus.pos  = pos_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_wave_scanner.sv
// Scoreboard bench for led_wave_scanner: N_LED=8 against a reference model,
// N_LED=2 and N_LED=13 against closed-form sequences.
module tb_led_wave_scanner;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    led_wave_scanner_if #(.N_LED(8))  b8 ();
    led_wave_scanner_if #(.N_LED(2))  b2 ();
    led_wave_scanner_if #(.N_LED(13)) b13 ();

    led_wave_scanner #(.N_LED(8))  u8  (.clk(clk), .rst(rst), .bus(b8));
    led_wave_scanner #(.N_LED(2))  u2  (.clk(clk), .rst(rst), .bus(b2));
    led_wave_scanner #(.N_LED(13)) u13 (.clk(clk), .rst(rst), .bus(b13));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tag;
        int          sel;
        logic [63:0] exp;
        string       name;
    } ent_t;

    ent_t sb[$];
    ent_t e;
    logic [63:0] act;

    function automatic logic [63:0] actual(int s);
        case (s)
            0: return 64'(b8.pos);
            1: return 64'(b8.q);
            2: return 64'(b8.wrap);
            3: return 64'(b2.pos);
            4: return 64'(b2.q);
            5: return 64'(b13.pos);
            6: return 64'(b13.wrap);
            7: return 64'(b13.q);
            default: return '1;
        endcase
    endfunction

    task automatic push(int s, string nm, logic [63:0] v);
        ent_t x;
        x.tag  = cyc + 1;
        x.sel  = s;
        x.exp  = v;
        x.name = nm;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e   = sb.pop_front();
            act = actual(e.sel);
            n_chk++;
            if (e.tag != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s cyc %0d: got %0h want %0h",
                         e.name, e.tag, act, e.exp);
            end
        end
    end

    int          m_cnt, m_pos, m_pwm;
    bit          m_up, m_wrap;
    logic [7:0]  m_q;

    function automatic logic [7:0] pat8(int p, logic [1:0] md);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (md == 2'd2) r[i] = (i <= p);
            else            r[i] = (i == p);
        end
        return r;
    endfunction

    task automatic model();
        int np;
        bit t;
        if (rst) begin
            m_cnt = 0; m_pos = 0; m_up = 1;
            m_pwm = 0; m_q = 8'h00; m_wrap = 0;
        end else begin
            m_q   = (m_pwm < int'(b8.duty)) ? pat8(m_pos, b8.mode) : 8'h00;
            m_pwm = (m_pwm + 1) % 16;
            t     = b8.en && (m_cnt >= int'(b8.rate));
            np    = m_pos;
            if (b8.en) m_cnt = t ? 0 : m_cnt + 1;
            if (t) begin
                case (b8.mode)
                    2'd0: begin
                        if (m_up && m_pos == 7) begin np = 6; m_up = 0; end
                        else if (m_up)          np = m_pos + 1;
                        else if (m_pos == 0)    begin np = 1; m_up = 1; end
                        else                    np = m_pos - 1;
                    end
                    2'd1, 2'd2: begin
                        np   = (m_pos + 1) % 8;
                        m_up = 1;
                    end
                    default: begin
                    end
                endcase
            end
            m_wrap = t && np == 0 && m_pos != 0;
            m_pos  = np;
        end
    endtask

    task automatic step();
        model();
        push(0, "pos8", 64'(m_pos));
        push(1, "q8", 64'(m_q));
        push(2, "wrap8", 64'(m_wrap));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        b8.en = 1'b0; b8.mode = 2'd0; b8.rate = '0; b8.duty = 4'd0;
        b2.en = 1'b1; b2.mode = 2'd0; b2.rate = '0; b2.duty = 4'd15;
        b13.en = 1'b1; b13.mode = 2'd1; b13.rate = '0; b13.duty = 4'd0;
        @(negedge clk);
        step();
        step();

        n_chk++;
        if (b8.pos !== 3'd0 || b8.q !== 8'h00 || b8.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8: pos %0h q %0h wrap %0b",
                     b8.pos, b8.q, b8.wrap);
        end

        rst = 1'b0;
        b8.en = 1'b1; b8.rate = 16'd3; b8.duty = 4'd15; b8.mode = 2'd0;
        repeat (120) step();

        b8.mode = 2'd1; b8.rate = 16'd0;
        repeat (20) step();

        b8.mode = 2'd2;
        for (int g = 0; g < 20 && m_pos != 5; g++) step();
        b8.en = 1'b0; b8.duty = 4'd8;
        repeat (34) step();

        b8.en = 1'b1; b8.duty = 4'd15; b8.mode = 2'd1; b8.rate = 16'd2;
        for (int g = 0; g < 40 && m_pos != 4; g++) step();
        b8.mode = 2'd3;
        repeat (20) step();

        b8.mode = 2'd1;
        repeat (5) step();
        b8.en = 1'b0;
        repeat (12) step();
        b8.en = 1'b1;
        repeat (12) step();

        b8.rate = 16'd100;
        for (int g = 0; g < 300 && m_cnt != 50; g++) step();
        b8.rate = 16'd10;
        repeat (3) step();

        b8.rate = 16'd0; b8.mode = 2'd0;
        for (int g = 0; g < 40 && !(m_up == 0 && m_pos == 3); g++) step();
        rst = 1'b1;
        step();

        n_chk++;
        if (b8.pos !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst pos: got %0h want 0", b8.pos);
        end
        n_chk++;
        if (b8.q !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst q: got %0h want 0", b8.q);
        end
        n_chk++;
        if (b8.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst wrap: got %0b want 0", b8.wrap);
        end

        rst = 1'b0;
        repeat (6) step();

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            push(3, "pos2", 64'(k % 2));
            push(4, "q2", ((k - 1) % 16 < 15) ? 64'(1 << ((k - 1) % 2)) : 64'd0);
            push(5, "pos13", 64'(k % 13));
            push(6, "wrap13", 64'(k % 13 == 0));
            push(7, "q13", 64'd0);
            step();
        end

        n_chk++;
        if (b13.q !== 13'h0) begin
            n_fail++;
            $display("FAIL q13 end: got %0h want 0", b13.q);
        end

        repeat (2) @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s cyc %0d: never compared", e.name, e.tag);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
